// File: rtl/gf_vec_add.sv
`default_nettype none
// ============================================================================
// Module   : gf_vec_add
// Purpose  : GF(2^FIELD) vector adder / XOR-reducer streaming two operand
//            BRAMs into a result write port under a start/done handshake.
//            Define GF_VEC_ADD_REG_OUT_EN to add one write-port register stage.
// Revision : 1.0 - initial release
// ============================================================================
module gf_vec_add #(
    parameter int FIELD      = 8,
    parameter int PARALLEL   = 4,
    parameter int N_WORDS    = 16,
    parameter int ADDR_WIDTH = (N_WORDS > 1) ? $clog2(N_WORDS) : 1
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic                      i_start,
    input  logic                      i_mode,
    output logic                      o_rd_en,
    output logic [ADDR_WIDTH-1:0]     o_rd_addr,
    input  logic [FIELD*PARALLEL-1:0] i_data_1,
    input  logic [FIELD*PARALLEL-1:0] i_data_2,
    output logic                      o_wr_en,
    output logic [ADDR_WIDTH-1:0]     o_wr_addr,
    output logic [FIELD*PARALLEL-1:0] o_wr_data,
    output logic                      o_busy,
    output logic                      o_done
);

    localparam int c_W = FIELD * PARALLEL;
    localparam logic [ADDR_WIDTH-1:0] c_LAST_ADDR = ADDR_WIDTH'(N_WORDS - 1);
`ifdef GF_VEC_ADD_REG_OUT_EN
    localparam logic [1:0] c_DRAIN_LAST = 2'd2;
`else
    localparam logic [1:0] c_DRAIN_LAST = 2'd1;
`endif

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic [ADDR_WIDTH-1:0] r_cnt;
    logic [1:0]            r_drain;
    logic                  r_mode;
    logic                  r_vld;
    logic                  r_last;
    logic [ADDR_WIDTH-1:0] r_addr_d;
    logic [c_W-1:0]        r_acc;
    logic                  r_wr_en;
    logic [ADDR_WIDTH-1:0] r_wr_addr;
    logic [c_W-1:0]        r_wr_data;
    logic [c_W-1:0]        w_sum;
    logic                  w_start;
    logic                  w_rd_last;

    assign w_sum     = i_data_1 ^ i_data_2;
    assign w_start   = (r_state == S_IDLE) && i_start;
    assign w_rd_last = (r_state == S_READ) && (r_cnt == c_LAST_ADDR);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (i_start) w_next = S_READ;
            S_READ:  if (r_cnt == c_LAST_ADDR) w_next = S_DRAIN;
            S_DRAIN: if (r_drain == c_DRAIN_LAST) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Read counter saturates at the last address and holds after READ.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt   <= '0;
            r_drain <= 2'd0;
            r_mode  <= 1'b0;
        end else begin
            if (w_start) begin
                r_cnt  <= '0;
                r_mode <= i_mode;
            end else if ((r_state == S_READ) && !w_rd_last) begin
                r_cnt <= r_cnt + ADDR_WIDTH'(1);
            end
            r_drain <= (r_state == S_DRAIN) ? (r_drain + 2'd1) : 2'd0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_vld    <= 1'b0;
            r_last   <= 1'b0;
            r_addr_d <= '0;
        end else begin
            r_vld    <= (r_state == S_READ);
            r_last   <= w_rd_last;
            r_addr_d <= r_cnt;
        end
    end

    // Write address/data hold their last value between writes.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_acc     <= '0;
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
        end else begin
            r_wr_en <= 1'b0;
            if (w_start) begin
                r_acc <= '0;
            end else if (r_vld) begin
                if (r_mode) begin
                    r_acc <= r_acc ^ w_sum;
                    if (r_last) begin
                        r_wr_en   <= 1'b1;
                        r_wr_addr <= '0;
                        r_wr_data <= r_acc ^ w_sum;
                    end
                end else begin
                    r_wr_en   <= 1'b1;
                    r_wr_addr <= r_addr_d;
                    r_wr_data <= w_sum;
                end
            end
        end
    end

`ifdef GF_VEC_ADD_REG_OUT_EN
    logic                  r_wr_en_q;
    logic [ADDR_WIDTH-1:0] r_wr_addr_q;
    logic [c_W-1:0]        r_wr_data_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_en_q   <= 1'b0;
            r_wr_addr_q <= '0;
            r_wr_data_q <= '0;
        end else begin
            r_wr_en_q   <= r_wr_en;
            r_wr_addr_q <= r_wr_addr;
            r_wr_data_q <= r_wr_data;
        end
    end

    assign o_wr_en   = r_wr_en_q;
    assign o_wr_addr = r_wr_addr_q;
    assign o_wr_data = r_wr_data_q;
`else
    assign o_wr_en   = r_wr_en;
    assign o_wr_addr = r_wr_addr;
    assign o_wr_data = r_wr_data;
`endif

    assign o_rd_en   = (r_state == S_READ);
    assign o_rd_addr = r_cnt;
    assign o_busy    = (r_state != S_IDLE);
    assign o_done    = (r_state == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_gf_vec_add.sv
`default_nettype none
// ============================================================================
// Module   : tb_gf_vec_add
// Purpose  : Self-checking bench for gf_vec_add (16-word and 1-word builds).
// Revision : 1.0 - initial release
// ============================================================================
module tb_gf_vec_add;

`ifdef GF_VEC_ADD_REG_OUT_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 2;
`endif
    localparam int NW = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        mode = 1'b0;
    logic        rd_en;
    logic [3:0]  rd_addr;
    logic [31:0] d1 = '0;
    logic [31:0] d2 = '0;
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [31:0] wr_data;
    logic        busy;
    logic        done;

    logic        b_start = 1'b0;
    logic        b_mode = 1'b0;
    logic        b_rd_en;
    logic [0:0]  b_rd_addr;
    logic [31:0] b_d1 = '0;
    logic [31:0] b_d2 = '0;
    logic        b_wr_en;
    logic [0:0]  b_wr_addr;
    logic [31:0] b_wr_data;
    logic        b_busy;
    logic        b_done;

    always #5 clk = ~clk;

    gf_vec_add #(.FIELD(8), .PARALLEL(4), .N_WORDS(NW)) u_dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_mode(mode),
        .o_rd_en(rd_en), .o_rd_addr(rd_addr), .i_data_1(d1), .i_data_2(d2),
        .o_wr_en(wr_en), .o_wr_addr(wr_addr), .o_wr_data(wr_data),
        .o_busy(busy), .o_done(done)
    );

    gf_vec_add #(.FIELD(8), .PARALLEL(4), .N_WORDS(1)) u_dut1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(b_start), .i_mode(b_mode),
        .o_rd_en(b_rd_en), .o_rd_addr(b_rd_addr), .i_data_1(b_d1), .i_data_2(b_d2),
        .o_wr_en(b_wr_en), .o_wr_addr(b_wr_addr), .o_wr_data(b_wr_data),
        .o_busy(b_busy), .o_done(b_done)
    );

    logic [31:0] mem1 [NW];
    logic [31:0] mem2 [NW];

    always @(posedge clk) begin
        if (rd_en) begin
            d1 <= mem1[rd_addr];
            d2 <= mem2[rd_addr];
        end
        if (b_rd_en) begin
            b_d1 <= (b_rd_addr == 1'b0) ? 32'hA5A5A5A5 : 32'hDEADBEEF;
            b_d2 <= (b_rd_addr == 1'b0) ? 32'h5A5A5A5A : 32'h12345678;
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        logic [3:0]  addr;
        logic [31:0] data;
    } wr_t;

    typedef struct {
        logic        mode;
        logic [31:0] mul1;
        logic [31:0] c2;
    } vec_t;

    wr_t  sbq[$];
    vec_t vecs[4];
    int   n_vec = 0;
    int   n_err = 0;
    int   b_t0, b_rel, b_nw, b_nd;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One run on the 16-word DUT; expectations are queued before start.
    task automatic run(input logic m, input logic [31:0] mul1, input logic [31:0] c2,
                       input bit spam, input int abort_at);
        logic [31:0] acc;
        int          t0, rel, n_done;
        wr_t         w;
        acc = '0;
        for (int j = 0; j < NW; j++) begin
            mem1[j] = mul1 * j;
            mem2[j] = c2;
            acc     = acc ^ mem1[j] ^ mem2[j];
        end
        if (m) begin
            sbq.push_back('{NW + LAT, 4'd0, acc});
        end else begin
            for (int j = 0; j < NW; j++)
                sbq.push_back('{j + 1 + LAT, 4'(j), mem1[j] ^ mem2[j]});
        end
        @(negedge clk);
        t0    = cyc;
        start = 1'b1;
        mode  = m;
        n_done = 0;
        for (int i = 0; i < NW + 12; i++) begin
            @(negedge clk);
            rel   = cyc - t0;
            start = spam && (rel >= 2) && (rel <= 10);
            mode  = ~m;
            if ((abort_at != 0) && (rel == abort_at)) begin
                rst_n = 1'b0;
                #1;
                check("rst_ctl", 32'({wr_en, rd_en, busy, done}), 32'h0);
                check("rst_addr", 32'({wr_addr, rd_addr}), 32'h0);
                check("rst_wdata", wr_data, 32'h0);
                repeat (6) begin
                    @(negedge clk);
                    check("rst_quiet", 32'({wr_en, rd_en, busy, done}), 32'h0);
                end
                rst_n = 1'b1;
                start = 1'b0;
                mode  = 1'b0;
                sbq.delete();
                return;
            end
            check("busy", 32'(busy), 32'((rel >= 1) && (rel <= NW + LAT + 1)));
            check("rd_en", 32'(rd_en), 32'((rel >= 1) && (rel <= NW)));
            if (rd_en) check("rd_addr", 32'(rd_addr), 32'(rel - 1));
            if (wr_en) begin
                if (sbq.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL wr_unexpected: write at cycle %0d addr %h data %h, none expected",
                             rel, wr_addr, wr_data);
                end else begin
                    w = sbq.pop_front();
                    check("wr_cycle", 32'(rel), 32'(w.cyc));
                    check("wr_addr", 32'(wr_addr), 32'(w.addr));
                    check("wr_data", wr_data, w.data);
                end
            end
            if (done) begin
                n_done++;
                check("done_cycle", 32'(rel), 32'(NW + LAT + 1));
            end
        end
        check("done_count", 32'(n_done), 32'd1);
        check("sb_left", 32'(sbq.size()), 32'd0);
        sbq.delete();
        start = 1'b0;
        mode  = 1'b0;
    endtask

    initial begin
        vecs[0] = '{1'b0, 32'h01020304, 32'hFFFFFFFF};
        vecs[1] = '{1'b1, 32'h00000001, 32'h00000000};
        vecs[2] = '{1'b0, 32'h11111111, 32'h0F0F0F0F};
        vecs[3] = '{1'b1, 32'h01020304, 32'hFFFFFFFF};

        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_ctl", 32'({rd_en, wr_en, busy, done}), 32'h0);
        check("reset_addr", 32'({rd_addr, wr_addr}), 32'h0);
        check("reset_wdata", wr_data, 32'h0);
        check("reset_b", 32'({b_rd_en, b_wr_en, b_busy, b_done, b_wr_data != 32'h0}), 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int v = 0; v < 4; v++)
            run(vecs[v].mode, vecs[v].mul1, vecs[v].c2, 1'b0, 0);

        // start re-asserted while busy must not launch a second run
        run(1'b0, 32'h01020304, 32'hFFFFFFFF, 1'b1, 0);
        // asynchronous reset in the middle of an add run, then a fresh run
        run(1'b0, 32'h01020304, 32'hFFFFFFFF, 1'b0, 8);
        run(1'b1, 32'h00010001, 32'h80000000, 1'b0, 0);

        // single-word instance in reduce mode
        @(negedge clk);
        b_t0    = cyc;
        b_start = 1'b1;
        b_mode  = 1'b1;
        b_nw    = 0;
        b_nd    = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            b_rel   = cyc - b_t0;
            b_start = 1'b0;
            b_mode  = 1'b0;
            check("b_rd_en", 32'(b_rd_en), 32'(b_rel == 1));
            if (b_wr_en) begin
                b_nw++;
                check("b_wr_cycle", 32'(b_rel), 32'(1 + LAT));
                check("b_wr_addr", 32'(b_wr_addr), 32'h0);
                check("b_wr_data", b_wr_data, 32'hFFFFFFFF);
            end
            if (b_done) begin
                b_nd++;
                check("b_done_cycle", 32'(b_rel), 32'(2 + LAT));
            end
        end
        check("b_wr_count", 32'(b_nw), 32'd1);
        check("b_done_count", 32'(b_nd), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
